// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD <-> binary conversion paths:
// FSM encoding and digit thresholds reused by the display converter.
package bcd_to_binary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] CORR_THRESH   = 4'd8;

  function automatic logic digit_bad(input logic [3:0] i_digit);
    return i_digit > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_to_binary_corrector.sv
// Per-digit reverse double-dabble correction: after a right shift a digit
// that landed at 8 or above carries a spurious +3 and must lose it.
module bcd_digit_corrector
  import bcd_to_binary_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= CORR_THRESH) ? i_digit - 4'd3 : i_digit;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter: one reverse double-dabble shift per
// clock with start/busy/done handshake and an error flag for non-BCD digits.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      result
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t              r_state;
  logic [WORK_W-1:0]   r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [BIN_W-1:0]    r_result;

  logic [WORK_W-1:0]   w_shift;
  logic [WORK_W-1:0]   w_next;
  logic [BCD_W-1:0]    w_corr;
  logic                w_bad;
  logic                w_accept;

  // Right shift moves the BCD LSB into the binary MSB, then each digit is corrected.
  assign w_shift = r_work >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corrector u_corr (
      .i_digit (w_shift[BIN_W + 4*g +: 4]),
      .o_digit (w_corr[4*g +: 4])
    );
  end

  assign w_next = {w_corr, w_shift[BIN_W-1:0]};

  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_bad(bcd_in[4*d +: 4])) w_bad = 1'b1;
    end
  end

  assign w_accept = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (w_bad) begin
              r_state  <= ST_DONE;
              r_err    <= 1'b1;
              r_result <= '0;
            end else begin
              r_state <= ST_SHIFT;
              r_err   <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_state  <= ST_DONE;
            r_result <= w_next[BIN_W-1:0];
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Working register is pure datapath; its contents only matter while in SHIFT.
  always_ff @(posedge clk) begin
    if (w_accept && !w_bad) begin
      r_work <= {bcd_in, {BIN_W{1'b0}}};
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_next;
    end
  end

  assign busy   = (r_state == ST_SHIFT);
  assign done   = (r_state == ST_DONE);
  assign err    = r_err;
  assign result = r_result;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: expected {err,result} queued at start,
// popped and compared on every done pulse.
module tb_bcd_to_binary;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [11:0]       bcd_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [BIN_W-1:0]  result;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_exp  = 0;
  logic [BIN_W:0] exp_q[$];
  logic [BIN_W:0] mon_e;

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check_eq("extra_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("result", 32'(result), 32'(mon_e[BIN_W-1:0]));
        check_eq("err", 32'(err), 32'(mon_e[BIN_W]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int exp_edges, input int exp_busy);
    int e = 0;
    int b = 0;
    while (done !== 1'b1 && e < 60) begin
      if (busy === 1'b1) b++;
      tick();
      e++;
    end
    check_eq("latency", e, exp_edges);
    check_eq("busy_cycles", b, exp_busy);
    tick();
    check_eq("done_pulse", 32'(done), 0);
  endtask

  task automatic convert(input logic [11:0] bcd, input int exp_res, input bit exp_err);
    exp_q.push_back({exp_err, BIN_W'(exp_res)});
    n_exp++;
    start  = 1'b1;
    bcd_in = bcd;
    tick();
    start  = 1'b0;
    bcd_in = 12'($urandom);
    if (exp_err) wait_done(0, 0);
    else         wait_done(BIN_W, BIN_W);
  endtask

  initial begin
    logic [11:0] b;
    resetn = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_result", 32'(result), 0);
    resetn = 1'b1;
    tick();

    convert(12'h255, 255, 1'b0);
    convert(12'h999, 999, 1'b0);
    convert(12'h000, 0, 1'b0);
    convert(12'h1A5, 0, 1'b1);
    convert(12'h042, 42, 1'b0);
    convert(12'hF0F, 0, 1'b1);
    convert(12'h90B, 0, 1'b1);
    convert(12'h123, 123, 1'b0);

    // Second start while busy must be dropped.
    exp_q.push_back({1'b0, BIN_W'(321)});
    n_exp++;
    start  = 1'b1;
    bcd_in = 12'h321;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    start  = 1'b1;
    bcd_in = 12'h777;
    tick();
    start  = 1'b0;
    wait_done(BIN_W - 4, BIN_W - 4);
    repeat (15) tick();

    // Reset in the middle of a conversion aborts it silently.
    start  = 1'b1;
    bcd_in = 12'h500;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_done", 32'(done), 0);
    check_eq("mid_rst_err", 32'(err), 0);
    check_eq("mid_rst_result", 32'(result), 0);
    resetn = 1'b1;
    repeat (15) tick();
    convert(12'h500, 500, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      convert(b, i, 1'b0);
    end

    repeat (3) tick();
    check_eq("done_count", n_done, n_exp);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
